// File: rtl/uart11_serial_pkg.sv
// Shared types for uart11_serial: bus FSM and receiver states, host-port addresses, parity helper.
// Optional even-parity framing is enabled by defining UART11_SERIAL_PARITY_EN.
package uart11_serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RXSTAT = 2'd1,
        RXWR   = 2'd2,
        TXRD   = 2'd3
    } bus_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_WAITHI = 3'd4
    } rx_state_t;

    localparam logic [2:0] HOST_TXDATA = 3'd0;
    localparam logic [2:0] HOST_RXSTAT = 3'd4;
    localparam int         STAT_BIT    = 31;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart11_serial_rx.sv
// Serial receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit sampling, stop/parity check.
// With UART11_SERIAL_PARITY_EN defined an even parity bit is expected between data and stop.
module uart11_serial_rx
    import uart11_serial_pkg::*;
#(
    parameter int CLKDIV = 434
) (
    input  logic       clk,
    input  logic       busrst_n,
    input  logic       rxd,
    output logic       byte_stb,
    output logic [7:0] byte_data,
    output logic       ferr
);

    localparam int            TW    = $clog2(CLKDIV);
    localparam logic [TW-1:0] TMAX  = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] THALF = TW'(CLKDIV / 2);
`ifdef UART11_SERIAL_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

    logic             meta_r;
    logic             sync_r;
    rx_state_t        state_r;
    logic [TW-1:0]    timer_r;
    logic [3:0]       idx_r;
    logic [NBITS-1:0] shift_r;
    logic             good_s;

    // Synchronise the asynchronous line; idle-high reset value avoids a false start.
    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= rxd;
            sync_r <= meta_r;
        end
    end

    // A byte is accepted only with a high stop sample (and even overall parity when built in).
    always_comb begin
`ifdef UART11_SERIAL_PARITY_EN
        good_s = sync_r & ~(^shift_r);
`else
        good_s = sync_r;
`endif
    end

    // Receive FSM; the start bit is re-checked half a bit after the falling edge.
    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            state_r   <= RX_IDLE;
            timer_r   <= '0;
            idx_r     <= 4'd0;
            shift_r   <= '0;
            byte_stb  <= 1'b0;
            byte_data <= 8'd0;
            ferr      <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            ferr     <= 1'b0;
            timer_r  <= (timer_r == TMAX) ? '0 : timer_r + TW'(1);
            case (state_r)
                RX_IDLE: begin
                    timer_r <= '0;
                    idx_r   <= 4'd0;
                    if (!sync_r) state_r <= RX_START;
                end
                RX_START: begin
                    if (timer_r == THALF) begin
                        timer_r <= '0;
                        state_r <= sync_r ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (timer_r == TMAX) begin
                        shift_r <= {sync_r, shift_r[NBITS-1:1]};
                        idx_r   <= idx_r + 4'd1;
                        if (idx_r == LAST_BIT) state_r <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (timer_r == TMAX) begin
                        if (good_s) begin
                            byte_stb  <= 1'b1;
                            byte_data <= shift_r[7:0];
                            state_r   <= RX_IDLE;
                        end else begin
                            ferr    <= 1'b1;
                            state_r <= sync_r ? RX_IDLE : RX_WAITHI;
                        end
                    end
                end
                RX_WAITHI: begin
                    if (sync_r) state_r <= RX_IDLE;
                end
                default: state_r <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart11_serial.sv
// Host-side master for the uart11 host port: TX FIFO -> serial line, serial line -> RX FIFO.
// Define UART11_SERIAL_PARITY_EN to add an even parity bit to every frame in both directions.
module uart11_serial
    import uart11_serial_pkg::*;
#(
    parameter int CLKDIV = 434
) (
    input  logic        clk,
    input  logic        busrst_n,
    output logic        uarthostreq,
    output logic [2:0]  uarthostaddr,
    output logic        uarthostwr,
    output logic [31:0] uarthostwdata,
    input  logic        uarthostack,
    input  logic [31:0] uarthostrdata,
    input  logic        rxd,
    output logic        txd,
    output logic        rxovr,
    output logic        rxferr
);

    localparam int            TW   = $clog2(CLKDIV);
    localparam logic [TW-1:0] TMAX = TW'(CLKDIV - 1);
`ifdef UART11_SERIAL_PARITY_EN
    localparam int TXBITS = 11;
`else
    localparam int TXBITS = 10;
`endif
    localparam logic [3:0] TX_LAST = 4'(TXBITS - 1);

    bus_state_t        state_r;
    logic              hold_full_r;
    logic [7:0]        hold_r;
    logic              tx_busy_r;
    logic [TW-1:0]     tx_timer_r;
    logic [3:0]        tx_idx_r;
    logic [TXBITS-2:0] tx_shift_r;
    logic              rx_stb_s;
    logic [7:0]        rx_byte_s;
    logic              hold_clr_s;
    logic              tx_load_s;
    logic              rdata_unused_s;

    uart11_serial_rx #(.CLKDIV(CLKDIV)) u_rx (
        .clk       (clk),
        .busrst_n  (busrst_n),
        .rxd       (rxd),
        .byte_stb  (rx_stb_s),
        .byte_data (rx_byte_s),
        .ferr      (rxferr)
    );

    assign hold_clr_s     = uarthostack && (state_r == RXWR);
    assign tx_load_s      = uarthostack && (state_r == TXRD) && uarthostrdata[STAT_BIT];
    assign rdata_unused_s = ^uarthostrdata[30:8];

    // Holding register; a store in the same cycle as the clear wins without overflow.
    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            hold_full_r <= 1'b0;
            hold_r      <= 8'd0;
            rxovr       <= 1'b0;
        end else begin
            rxovr <= 1'b0;
            if (rx_stb_s && (!hold_full_r || hold_clr_s)) begin
                hold_full_r <= 1'b1;
                hold_r      <= rx_byte_s;
            end else if (rx_stb_s) begin
                rxovr <= 1'b1;
            end else if (hold_clr_s) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    // Bus FSM: one-cycle req, fields held until ack, RX path served first.
    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            state_r       <= IDLE;
            uarthostreq   <= 1'b0;
            uarthostaddr  <= 3'd0;
            uarthostwr    <= 1'b0;
            uarthostwdata <= 32'd0;
        end else begin
            uarthostreq <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hold_full_r) begin
                        state_r       <= RXSTAT;
                        uarthostreq   <= 1'b1;
                        uarthostaddr  <= HOST_RXSTAT;
                        uarthostwr    <= 1'b0;
                        uarthostwdata <= 32'd0;
                    end else if (!tx_busy_r) begin
                        state_r       <= TXRD;
                        uarthostreq   <= 1'b1;
                        uarthostaddr  <= HOST_TXDATA;
                        uarthostwr    <= 1'b0;
                        uarthostwdata <= 32'd0;
                    end
                end
                RXSTAT: begin
                    if (uarthostack) begin
                        if (uarthostrdata[STAT_BIT]) begin
                            state_r       <= RXWR;
                            uarthostreq   <= 1'b1;
                            uarthostaddr  <= HOST_RXSTAT;
                            uarthostwr    <= 1'b1;
                            uarthostwdata <= {24'd0, hold_r};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                RXWR: begin
                    if (uarthostack) begin
                        state_r    <= IDLE;
                        uarthostwr <= 1'b0;
                    end
                end
                TXRD: begin
                    if (uarthostack) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // TX shifter: start bit drives the line the cycle after the popped byte is acked.
    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            txd        <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_timer_r <= '0;
            tx_idx_r   <= 4'd0;
            tx_shift_r <= '0;
        end else if (tx_load_s) begin
            txd        <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_timer_r <= '0;
            tx_idx_r   <= 4'd0;
`ifdef UART11_SERIAL_PARITY_EN
            tx_shift_r <= {1'b1, even_parity(uarthostrdata[7:0]), uarthostrdata[7:0]};
`else
            tx_shift_r <= {1'b1, uarthostrdata[7:0]};
`endif
        end else if (tx_busy_r) begin
            if (tx_timer_r == TMAX) begin
                tx_timer_r <= '0;
                if (tx_idx_r == TX_LAST) begin
                    tx_busy_r <= 1'b0;
                    txd       <= 1'b1;
                end else begin
                    txd        <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[TXBITS-2:1]};
                    tx_idx_r   <= tx_idx_r + 4'd1;
                end
            end else begin
                tx_timer_r <= tx_timer_r + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart11_serial.sv
// Self-checking bench for uart11_serial: a uart11 host-port model with TX/RX FIFOs, serial
// driver and decoder, and scoreboards for both directions.
module tb_uart11_serial;

    localparam int CLKDIV = 16;
    localparam int RXCAP  = 2;
`ifdef UART11_SERIAL_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        busrst_n;
    logic        req;
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        rxd;
    logic        txd;
    logic        rxovr;
    logic        rxferr;

    int total = 0;
    int bad   = 0;
    logic [7:0] tx_fifo[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] rx_exp[$];
    logic        mon_en    = 1'b1;
    logic        mon_busy  = 1'b0;
    int          tx_frames = 0;
    int          ovr_cnt   = 0;
    int          ferr_cnt  = 0;
    int          stat_retry = 0;
    logic        pend;
    logic        p_wr;
    logic [2:0]  p_addr;
    logic [31:0] p_wdata;

    uart11_serial #(.CLKDIV(CLKDIV)) dut (
        .clk           (clk),
        .busrst_n      (busrst_n),
        .uarthostreq   (req),
        .uarthostaddr  (addr),
        .uarthostwr    (wr),
        .uarthostwdata (wdata),
        .uarthostack   (ack),
        .uarthostrdata (rdata),
        .rxd           (rxd),
        .txd           (txd),
        .rxovr         (rxovr),
        .rxferr        (rxferr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic stop);
`ifdef UART11_SERIAL_PARITY_EN
        return {stop, ^b, b, 1'b0};
`else
        return {1'b0, stop, b, 1'b0};
`endif
    endfunction

    // uart11 host-port model: ack one cycle after req, FIFOs behind addresses 0 and 4.
    initial begin
        ack  = 1'b0;
        rdata = 32'd0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            ack   = 1'b0;
            rdata = 32'd0;
            if (!busrst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                chk("bus_hold", {req, addr, wr, wdata}, {1'b0, p_addr, p_wr, p_wdata});
                ack  = 1'b1;
                pend = 1'b0;
                if (p_wr) begin
                    chk("wr_addr", p_addr, 3'd4);
                    chk("wdata_hi", p_wdata[31:8], 24'd0);
                    chk("rx_room", rx_fifo.size() < RXCAP, 1'b1);
                    chk("rx_exp_avail", rx_exp.size() != 0, 1'b1);
                    if (rx_exp.size() != 0) chk("rx_byte", p_wdata[7:0], rx_exp.pop_front());
                    rx_fifo.push_back(p_wdata[7:0]);
                end else if (p_addr == 3'd0) begin
                    if (tx_fifo.size() != 0) rdata = {1'b1, 23'd0, tx_fifo.pop_front()};
                end else begin
                    chk("rd_addr", p_addr, 3'd4);
                    if (rx_fifo.size() < RXCAP) rdata = 32'h8000_0000;
                    else stat_retry++;
                end
            end else if (req) begin
                pend    = 1'b1;
                p_addr  = addr;
                p_wr    = wr;
                p_wdata = wdata;
            end
        end
    end

    // Serial decoder: samples each bit mid-cell and checks it against the expected frame.
    initial begin
        logic [10:0] fr;
        logic        abort;
        forever begin
            @(negedge clk);
            if (mon_en && busrst_n && txd == 1'b0) begin
                mon_busy = 1'b1;
                abort    = 1'b0;
                chk("tx_expected", tx_exp.size() != 0, 1'b1);
                fr = (tx_exp.size() != 0) ? frame_of(tx_exp.pop_front(), 1'b1) : 11'h7ff;
                for (int i = 0; i < NB; i++) begin
                    repeat ((i == 0) ? 7 : CLKDIV) @(negedge clk);
                    if (!mon_en) begin
                        abort = 1'b1;
                        break;
                    end
                    chk($sformatf("tx_bit%0d", i), txd, fr[i]);
                end
                if (!abort) tx_frames++;
                mon_busy = 1'b0;
            end
        end
    end

    // Pulse monitor for rxovr/rxferr: counts pulses and checks each lasts one cycle.
    initial begin
        logic ovr_prev  = 1'b0;
        logic ferr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rxovr) begin
                chk("ovr_pulse", ovr_prev, 1'b0);
                ovr_cnt++;
            end
            if (rxferr) begin
                chk("ferr_pulse", ferr_prev, 1'b0);
                ferr_cnt++;
            end
            ovr_prev  = rxovr;
            ferr_prev = rxferr;
        end
    end

    task automatic cpu_tx(input logic [7:0] b);
        tx_fifo.push_back(b);
        tx_exp.push_back(b);
    endtask

    task automatic cpu_rx_read(input logic [7:0] exp);
        chk("rcsr_done", rx_fifo.size() != 0, 1'b1);
        if (rx_fifo.size() != 0) chk("rbuf", {8'h00, rx_fifo.pop_front()}, {8'h00, exp});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [10:0] f;
        f = frame_of(b, stop);
        for (int i = 0; i < NB; i++) begin
            rxd = f[i];
            repeat (CLKDIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CLKDIV) @(negedge clk);
    endtask

    task automatic wait_tx_quiet(input int budget);
        int n;
        n = 0;
        while ((tx_fifo.size() != 0 || tx_exp.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("tx_quiet", n < budget, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rxd      = 1'b1;
        busrst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_req", req, 1'b0);
        chk("rst_wr", wr, 1'b0);
        chk("rst_addr", addr, 3'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rxovr", rxovr, 1'b0);
        chk("rst_rxferr", rxferr, 1'b0);
        busrst_n = 1'b1;

        cpu_tx(8'h41);
        wait_tx_quiet(400);
        chk("frames_41", tx_frames, 1);
        chk("txd_idle1", txd, 1'b1);

        cpu_tx(8'h55);
        cpu_tx(8'hAA);
        wait_tx_quiet(800);
        chk("frames_55aa", tx_frames, 3);
        chk("txd_idle2", txd, 1'b1);

        rx_exp.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        cpu_rx_read(8'h5A);
        chk("ovr_none", ovr_cnt, 0);
        chk("ferr_none", ferr_cnt, 0);

        rx_exp.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        rx_exp.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        rx_exp.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        chk("ovr_once", ovr_cnt, 1);
        chk("rx_full", rx_fifo.size(), RXCAP);
        chk("stat_retried", stat_retry > 0, 1'b1);
        cpu_rx_read(8'h11);
        repeat (20) @(negedge clk);
        chk("held_written", rx_fifo.size(), RXCAP);
        cpu_rx_read(8'h22);
        cpu_rx_read(8'h33);
        chk("rx_exp_drained", rx_exp.size(), 0);

        send_frame(8'h33, 1'b0);
        repeat (10) @(negedge clk);
        chk("ferr_once", ferr_cnt, 1);
        chk("ferr_nowrite", rx_fifo.size(), 0);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_nowrite", rx_fifo.size(), 0);
        chk("glitch_noferr", ferr_cnt, 1);
        rx_exp.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        repeat (10) @(negedge clk);
        cpu_rx_read(8'h96);
        chk("ovr_still_once", ovr_cnt, 1);

        cpu_tx(8'h77);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_started", txd, 1'b0);
        repeat (40) @(negedge clk);
        mon_en   = 1'b0;
        busrst_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_req", req, 1'b0);
        repeat (3) @(negedge clk);
        busrst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("postrst_idle", txd, 1'b1);
        mon_en = 1'b1;
        cpu_tx(8'h3C);
        wait_tx_quiet(400);
        chk("frames_after_rst", tx_frames, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
